// File: rtl/mips16_dbg_pkg.sv
// Shared state and status encodings for the mips16 run controller.
// Imported by the controller top and its trace storage.
package mips16_dbg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } run_state_t;

  localparam logic [1:0] STAT_NONE    = 2'd0;
  localparam logic [1:0] STAT_HALT    = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;
  localparam logic [1:0] STAT_ABORT   = 2'd3;

endpackage

// File: rtl/mips16_trace_ram.sv
// Trace storage: one write port, one registered read port.
// Storage is not reset; validity is tracked by the controller.
module mips16_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Sample write into the array
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read, one cycle after the address
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips16_run_ctrl.sv
// Run controller: holds the core in reset, runs it, detects
// halt/timeout/abort and keeps a circular (pc, alu) trace.
module mips16_run_ctrl
  import mips16_dbg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 5,
  parameter int MAX_CYCLES  = 250,
  parameter int STALL_LIMIT = 8,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            alu_in,
  output logic                         core_reset,
  output logic                         running,
  output logic                         done,
  output logic [1:0]                   status,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]            rd_pc,
  output logic [DATA_W-1:0]            rd_alu
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int TW = AW + 1;
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CYC_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [TW-1:0]    TR_FULL   = TW'(TRACE_DEPTH);

  run_state_t state_q, state_d;

  logic [HW-1:0]       hold_q, hold_d;
  logic [SW-1:0]       stall_q, stall_d, stall_inc;
  logic [CNT_W-1:0]    cyc_d, cyc_inc;
  logic [TW-1:0]       tcnt_d;
  logic [AW-1:0]       wptr_q, wptr_d, rd_idx;
  logic [1:0]          status_d;
  logic [DATA_W-1:0]   pc_prev_q;
  logic [2*DATA_W-1:0] rd_data;
  logic                pc_same, stall_hit, we, rd_ok_q;

  assign cyc_inc   = cycle_count + CNT_W'(1);
  assign stall_inc = stall_q + SW'(1);
  // First RUN cycle has no meaningful previous pc
  assign pc_same   = (cycle_count != '0) && (pc_in == pc_prev_q);
  assign stall_hit = pc_same && (stall_inc == STALL_MAX);

  // Next-state, counters and exit decision
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stall_d  = stall_q;
    cyc_d    = cycle_count;
    tcnt_d   = trace_count;
    wptr_d   = wptr_q;
    status_d = status;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_HOLD;
          hold_d   = '0;
          stall_d  = '0;
          cyc_d    = '0;
          tcnt_d   = '0;
          wptr_d   = '0;
          status_d = STAT_NONE;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + HW'(1);
      end
      S_RUN: begin
        we      = 1'b1;
        cyc_d   = cyc_inc;
        wptr_d  = wptr_q + AW'(1);
        stall_d = pc_same ? stall_inc : '0;
        if (trace_count != TR_FULL) tcnt_d = trace_count + TW'(1);
        if (abort) begin
          state_d  = S_DONE;
          status_d = STAT_ABORT;
        end else if (stall_hit) begin
          state_d  = S_DONE;
          status_d = STAT_HALT;
        end else if (cyc_inc == CYC_MAX) begin
          state_d  = S_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered state-decoded outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      stall_q     <= '0;
      cycle_count <= '0;
      trace_count <= '0;
      wptr_q      <= '0;
      status      <= STAT_NONE;
      pc_prev_q   <= '0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_q     <= stall_d;
      cycle_count <= cyc_d;
      trace_count <= tcnt_d;
      wptr_q      <= wptr_d;
      status      <= status_d;
      pc_prev_q   <= pc_in;
      core_reset  <= (state_d != S_RUN);
      running     <= (state_d == S_RUN);
      done        <= (state_d == S_DONE);
    end
  end

  // Map logical index (0 = oldest) onto the circular buffer
  assign rd_idx = wptr_q - trace_count[AW-1:0] + rd_addr;

  // Remember whether the requested entry holds valid data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_ok_q <= 1'b0;
    else       rd_ok_q <= ({1'b0, rd_addr} < trace_count);
  end

  mips16_trace_ram #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_trace (
    .clk     (clk),
    .we      (we),
    .wr_addr (wptr_q),
    .wr_data ({pc_in, alu_in}),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  assign rd_pc  = rd_ok_q ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign rd_alu = rd_ok_q ? rd_data[DATA_W-1:0]        : '0;

endmodule

// File: doc/mips16_run_ctrl.md
Name: mips16_run_ctrl

Overview:
Synthesizable run controller for the mips_16 core, used for on-chip bring-up and regression runs. Holds the core in reset, releases it after a programmable hold, then monitors pc_out and alu_result every cycle. Ends a run on halt (PC stuck), cycle budget exhausted, or abort, then freezes the core. Keeps a circular trace of the last TRACE_DEPTH (pc, alu) samples for readback; sits between the board/debug interface and the core's reset input.

Parameters:
DATA_W, 16, width of pc_in, alu_in and trace data
CNT_W, 16, width of cycle_count; MAX_CYCLES must be at most 2^CNT_W-1
RST_CYCLES, 5, cycles core_reset is held after start (minimum 1)
MAX_CYCLES, 250, RUN-cycle budget before timeout (minimum 1)
STALL_LIMIT, 8, consecutive repeated-PC samples that declare halt (minimum 1)
TRACE_DEPTH, 16, trace entries; must be a power of 2, minimum 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
abort  in  1  level; ends a run while in RUN
pc_in  in  DATA_W  core pc_out
alu_in  in  DATA_W  core alu_result
core_reset  out  1  drives the core reset
running  out  1  high in RUN
done  out  1  high in DONE
status  out  2  0 none, 1 halt, 2 timeout, 3 abort
cycle_count  out  CNT_W  RUN cycles elapsed in current/last run
trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
rd_addr  in  $clog2(TRACE_DEPTH)  trace index; 0 = oldest valid entry
rd_pc  out  DATA_W  registered trace pc
rd_alu  out  DATA_W  registered trace alu

Behaviour:
- Reset (async): state IDLE. core_reset=1. running, done, status, cycle_count, trace_count, rd_pc and rd_alu are all 0. Internal counters and the write pointer are 0. Trace RAM contents are don't-care.
- States IDLE, HOLD, RUN, DONE. core_reset=1 in IDLE, HOLD and DONE; 0 only in RUN. Outputs are registered and decoded from state.
- IDLE/DONE + start -> HOLD. The same edge clears status, cycle_count, trace_count, the write pointer and the stall counter.
- start is ignored in HOLD and RUN. abort is ignored outside RUN.
- HOLD lasts exactly RST_CYCLES cycles, then -> RUN.
- RUN, every cycle:
  - cycle_count increments.
  - (pc_in, alu_in) is written at the write pointer; the pointer wraps modulo TRACE_DEPTH.
  - trace_count increments, saturating at TRACE_DEPTH.
- Stall tracking in RUN: pc_prev is registered every cycle. stall_cnt increments when pc_in == pc_prev, except on the first RUN cycle; otherwise it clears to 0.
- Exit to DONE happens at the edge where any of these is true; that cycle's sample is still recorded:
  - abort is high -> status 3.
  - stall_cnt would reach STALL_LIMIT -> status 1.
  - cycle_count would reach MAX_CYCLES -> status 2.
- Simultaneous exit conditions: priority abort > halt > timeout.
- DONE holds status, cycle_count and trace contents until the next start or reset.
- Trace read:
  - rd_pc/rd_alu update one cycle after rd_addr.
  - Physical index is (wr_ptr - trace_count + rd_addr) mod TRACE_DEPTH.
  - rd_addr >= trace_count returns 0.
  - Reads are valid in any state; the value is stable in DONE.
- Reset mid-run: core_reset asserts immediately (asynchronously) and the run is discarded.

Decomposition:
- Package mips16_dbg_pkg holds:
  - state encoding localparams;
  - status codes STAT_NONE, STAT_HALT, STAT_TIMEOUT, STAT_ABORT.
- One sub-module, mips16_trace_ram:
  - parametrised by depth and width;
  - one write port and one registered read port;
  - no reset on the storage array.

Test Plan:
1. Reset 5 cycles, start pulse at cycle 10 -> core_reset stays 1 for 5 cycles after start, then 0. running=1 from the 6th cycle after start.
2. pc_in = 2*n, never repeating, defaults -> after 250 RUN cycles done=1, status=2, cycle_count=250, trace_count=16. rd_addr 0 gives the pc of RUN cycle 235; rd_addr 15 gives that of cycle 250.
3. pc_in held at 0x0040 from RUN cycle 11 (cycles numbered from 1) -> DONE at cycle 19, status=1, cycle_count=19. rd_addr 15 gives rd_pc=0x0040.
4. abort asserted in the same cycle timeout would fire (MAX_CYCLES=20) -> status=3, cycle_count=20. A second start restarts cleanly with status=0.
5. MAX_CYCLES=6, alu_in = 0xA000+n -> trace_count=6. rd_addr 0 gives rd_alu=0xA001; rd_addr 6 gives 0.
6. Async reset pulse mid-RUN at cycle 40 -> same-cycle core_reset=1, state IDLE, cycle_count=0, trace_count=0. start then begins a normal run.
